data_ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and access sequencer in front of the byte-lane data RAM.
- Requester 0 is the CPU MEM stage; requester 1 is a DMA/debug load-store port.
- Serialises accesses into a fixed 3-cycle sequence: IDLE -> ACCESS -> DONE. Drives the RAM chip-enable, write-enable, address, byte-select and write data from registers, and returns registered read data with a one-cycle valid pulse.
- Raises a stall to the pipeline while the CPU request is outstanding.

---
 rtl/data_ram_arbiter.sv | 88 ++++++++
 tb/tb_data_ram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-requester round-robin arbiter sequencing RAM accesses IDLE->ACCESS->DONE
// clk/rst: clock, async active-high reset
// m0_*/m1_*: requester command (req, we, addr, sel, wdata) and response (gnt, rvalid, rdata); m0_stall to pipeline
// ram_*: registered RAM command (ce, we, addr, sel, wdata) and combinational ram_rdata
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic owner, ptr, c_we, win1, acc, done, start;
  logic [ADDR_W-1:0] c_addr;
  logic [3:0] c_sel;
  logic [DATA_W-1:0] c_wdata;
  // m1 wins when alone, or when both ask and the pointer names it
  assign win1 = m1_req & (~m0_req | ptr);
  assign start = (state == IDLE) & (m0_req | m1_req);
  assign acc = state == ACCESS;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = IDLE;
    state_nx = start ? ACCESS : acc ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 1'b0;
      ptr <= 1'b0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_sel <= '0;
      c_wdata <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (start) begin
        owner <= win1;
        ptr <= ~win1;
        c_we <= win1 ? m1_we : m0_we;
        c_addr <= win1 ? m1_addr : m0_addr;
        c_sel <= win1 ? m1_sel : m0_sel;
        c_wdata <= win1 ? m1_wdata : m0_wdata;
      end
      // writes complete with zero read data
      if (acc && !owner) m0_rdata <= c_we ? '0 : ram_rdata;
      if (acc && owner) m1_rdata <= c_we ? '0 : ram_rdata;
    end
  end
  assign ram_ce = acc;
  assign ram_we = acc & c_we & (|c_sel);
  assign ram_addr = acc ? c_addr : '0;
  assign ram_sel = acc ? c_sel : '0;
  assign ram_wdata = acc ? c_wdata : '0;
  assign m0_gnt = acc & ~owner;
  assign m1_gnt = acc & owner;
  assign m0_rvalid = done & ~owner;
  assign m1_rvalid = done & owner;
  assign m0_stall = m0_req & ~m0_rvalid;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed and random checks of data_ram_arbiter against a cycle-timed transaction model
module tb_data_ram_arbiter;
  logic clk = 0, rst = 0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic m0_gnt, m0_rvalid, m0_stall, m1_gnt, m1_rvalid, ram_ce, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0] ram_sel;
  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  int n_chk = 0, n_fail = 0;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  assign ram_rdata = ram[ram_addr[7:2]];
  always @(posedge clk) if (ram_ce && ram_we) ram[ram_addr[7:2]] <= merge(ram[ram_addr[7:2]], ram_wdata, ram_sel);

  // Transaction model: a grant decided at the end of an idle cycle makes the
  // next cycle the access (gnt) and the one after it the completion (rvalid).
  int cyc = 0, start = -10;
  logic busy = 0, cur_o = 0, cur_we = 0, ptr_m = 0;
  logic [31:0] cur_a = 0, cur_d = 0;
  logic [3:0] cur_s = 0;
  logic [31:0] mr [2] = '{32'h0, 32'h0};
  logic w1, e_acc, e_done;
  assign w1 = m1_req && (!m0_req || ptr_m);
  assign e_acc = busy && cyc == start;
  assign e_done = busy && cyc == start + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 0;
      ptr_m <= 0;
      mr[0] <= 0;
      mr[1] <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!busy) begin
        if (m0_req || m1_req) begin
          busy <= 1;
          start <= cyc + 1;
          cur_o <= w1;
          ptr_m <= !w1;
          cur_we <= w1 ? m1_we : m0_we;
          cur_a <= w1 ? m1_addr : m0_addr;
          cur_s <= w1 ? m1_sel : m0_sel;
          cur_d <= w1 ? m1_wdata : m0_wdata;
        end
      end else if (cyc == start) begin
        mr[cur_o] <= cur_we ? 32'h0 : ref_mem[cur_a[7:2]];
        if (cur_we && cur_s != 0) ref_mem[cur_a[7:2]] <= merge(ref_mem[cur_a[7:2]], cur_d, cur_s);
      end else busy <= 0;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m0_gnt", m0_gnt, e_acc && !cur_o);
    chk("m1_gnt", m1_gnt, e_acc && cur_o);
    chk("m0_rvalid", m0_rvalid, e_done && !cur_o);
    chk("m1_rvalid", m1_rvalid, e_done && cur_o);
    chk("m0_rdata", m0_rdata, mr[0]);
    chk("m1_rdata", m1_rdata, mr[1]);
    chk("m0_stall", m0_stall, m0_req && !(e_done && !cur_o));
    chk("ram_ce", ram_ce, e_acc);
    chk("ram_we", ram_we, e_acc && cur_we && cur_s != 0);
    if (e_acc) begin
      chk("ram_addr", ram_addr, cur_a);
      chk("ram_sel", ram_sel, cur_s);
      chk("ram_wdata", ram_wdata, cur_d);
    end
  end

  task automatic set_cmd(input int i, input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if (i == 0) begin m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = d; m0_req = 1; end
    else begin m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = d; m1_req = 1; end
  endtask

  task automatic drop(input int i);
    if (i == 0) m0_req = 0;
    else m1_req = 0;
  endtask

  task automatic rnd_cmd(input int i);
    set_cmd(i, 1'($urandom), $urandom & 32'h000100FC, ($urandom % 8 == 0) ? 4'h0 : 4'($urandom), $urandom);
  endtask

  task automatic wait_rv(input int i, output logic [31:0] rd, output int lat, output logic st);
    logic got = 0;
    rd = 0; lat = 0; st = 1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (i == 0 ? m0_rvalid : m1_rvalid) begin
        got = 1;
        rd = i == 0 ? m0_rdata : m1_rdata;
        st = m0_stall;
      end
    end
    #1 drop(i);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL rvalid_timeout m%0d: got none expected pulse within 10 cycles", i);
    end
  endtask

  logic [31:0] rd;
  int lat, ng;
  logic st, g0, g1, r0, r1, found;
  logic [3:0] ord;
  logic pend [2], gseen [2];
  int wcnt [2];

  initial begin
    for (int k = 0; k < 64; k++) begin
      ram[k] = $urandom;
      ref_mem[k] = ram[k];
    end
    ram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    ram[8] = 32'hAAAAAAAA; ref_mem[8] = 32'hAAAAAAAA;
    ram[12] = 32'h55AA55AA; ref_mem[12] = 32'h55AA55AA;
    ram[16] = 32'h0BADF00D; ref_mem[16] = 32'h0BADF00D;
    #1 rst = 1;
    #1;
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_ram_ce", ram_ce, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    // single m0 read
    set_cmd(0, 0, 32'h10, 4'hF, 32'h0);
    wait_rv(0, rd, lat, st);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_latency", lat, 2);
    chk("t1_stall_at_rvalid", st, 1'b0);
    // m1 partial write acknowledged with zero data
    set_cmd(1, 1, 32'h20, 4'b0011, 32'h12345678);
    wait_rv(1, rd, lat, st);
    chk("t2_write_rdata", rd, 32'h0);
    // both requesting continuously: strict alternation starting with m0
    set_cmd(0, 0, 32'h10, 4'hF, 32'h0);
    set_cmd(1, 0, 32'h20, 4'hF, 32'h0);
    ord = 0; ng = 0;
    repeat (12) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin ord = {ord[2:0], m1_gnt}; ng++; end
    end
    #1 begin drop(0); drop(1); end
    chk("t3_order", ord, 4'b0101);
    chk("t3_count", ng, 4);
    // read back the partially written word
    set_cmd(0, 0, 32'h20, 4'hF, 32'h0);
    wait_rv(0, rd, lat, st);
    chk("t2_readback", rd, 32'hAAAA5678);
    // sel = 0 write is acknowledged but leaves memory alone
    set_cmd(0, 1, 32'h30, 4'h0, 32'hFFFFFFFF);
    wait_rv(0, rd, lat, st);
    chk("t4_rdata", rd, 32'h0);
    chk("t4_mem", ram[12], 32'h55AA55AA);
    // reset in the middle of an m1 write
    repeat (2) @(negedge clk);
    #1 set_cmd(1, 1, 32'h40, 4'hF, 32'hFFFFFFFF);
    @(posedge clk);
    #2 chk("t6_we_before_rst", ram_we, 1'b1);
    rst = 1;
    #1;
    chk("t6_we_after_rst", ram_we, 1'b0);
    chk("t6_ce_after_rst", ram_ce, 1'b0);
    chk("t6_gnt_after_rst", m1_gnt, 1'b0);
    drop(1);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t6_mem", ram[16], 32'h0BADF00D);
    #1 begin set_cmd(0, 0, 32'h44, 4'hF, 0); set_cmd(1, 0, 32'h48, 4'hF, 0); end
    found = 0; g0 = 0; g1 = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin found = 1; g0 = m0_gnt; g1 = m1_gnt; end
    end
    #1 chk("t6_first_grant", {g0, g1}, 2'b10);
    wait_rv(0, rd, lat, st);
    wait_rv(1, rd, lat, st);
    // random traffic
    pend = '{0, 0}; gseen = '{0, 0}; wcnt = '{0, 0};
    repeat (1500) begin
      @(negedge clk);
      r0 = m0_rvalid; r1 = m1_rvalid; g0 = m0_gnt; g1 = m1_gnt;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          wcnt[i]++;
          if (i == 0 ? g0 : g1) gseen[i] = 1;
          if (i == 0 ? r0 : r1) begin
            drop(i); pend[i] = 0;
            if ($urandom % 4 == 0) begin rnd_cmd(i); pend[i] = 1; gseen[i] = 0; wcnt[i] = 0; end
          end else if (wcnt[i] > 12) begin
            n_chk++; n_fail++;
            $display("FAIL random_timeout m%0d: got no rvalid expected one within 12 cycles", i);
            drop(i); pend[i] = 0;
          end else if (!gseen[i] && $urandom % 4 == 0) rnd_cmd(i);
        end else if ($urandom % 3 == 0) begin
          rnd_cmd(i); pend[i] = 1; gseen[i] = 0; wcnt[i] = 0;
        end
      end
    end
    #1 begin drop(0); drop(1); end
    repeat (6) @(negedge clk);
    for (int k = 0; k < 64; k++) chk("final_mem", ram[k], ref_mem[k]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
